bin_to_bcd6: RTL and testbench
==============================

BIN_TO_BCD6 -- requirements
Module: bin_to_bcd6

Interface
REQ-001 Parameters SHALL be none; widths come from the shared package (BIN_W=20, NDIG=6).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request conversion of binIn; sampled only in IDLE.
REQ-005 binIn  input  20  unsigned binary value to convert.
REQ-006 busy  output  1  conversion in progress; high in SHIFT and LOAD.
REQ-007 done  output  1  one-cycle pulse; new digits valid.
REQ-008 ovf  output  1  registered; captured value > 999999.
REQ-009 dig0..dig5  output  4 each  BCD digits, dig0 least significant; feed the six-digit hex decoder's hexIn0..hexIn5 directly.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and LOAD.
REQ-011 IDLE: on start=1 at edge k, capture binIn into a shift register, clear the 28-bit BCD scratch (7 digits) and the 5-bit iteration counter, and go to SHIFT.
REQ-012 SHIFT: each cycle, apply add-3 to every scratch digit >= 5, then shift {scratch, bin} left by 1 and increment the counter.
REQ-013 SHIFT SHALL run exactly 20 iterations (edges k+1..k+20), then go to LOAD.
REQ-014 LOAD (edge k+21): register dig0..dig5 and ovf, pulse done for exactly one cycle, and return to IDLE.
REQ-015 Fixed latency SHALL be 21 cycles from start sample to done high, independent of value.
REQ-016 start while busy=1 SHALL be ignored and not queued.
REQ-017 start sampled in the cycle done is high SHALL be accepted (FSM is already IDLE).
REQ-018 start held high continuously SHALL produce back-to-back conversions every 22 cycles.
REQ-019 binIn SHALL be sampled only at the accepting edge; later changes have no effect.
REQ-020 dig0..dig5 and ovf SHALL hold their values between done pulses.
REQ-021 ovf SHALL be 1 when scratch digit 6 is nonzero (value >= 1000000), otherwise 0.

Reset
REQ-022 rst=1 at any edge SHALL force IDLE, busy=0, done=0, ovf=0, dig0..dig5=0, and clear the counter and scratch.
REQ-023 Reset mid-conversion SHALL abort it with no done pulse.
REQ-024 rst has priority over start in the same cycle.

Configuration
REQ-025 Macro BCD_OVF_SATURATE_EN SHALL select overflow handling.
REQ-026 Defined: when ovf=1, LOAD writes 9 to all six digits (999999).
REQ-027 Undefined: LOAD writes the low six scratch digits (value mod 1000000).
REQ-028 ovf behaviour SHALL be identical in both builds.

Structure
REQ-029 Package copper_bcd_pkg SHALL hold BIN_W, NDIG, ITER_LAST=19, MAX_DEC=999999 and the FSM state typedef.
REQ-030 Sub-module bcd_add3 (4-bit in, 4-bit out, combinational: +3 when >= 5) SHALL be instantiated once per scratch digit, 7 instances.

Verification
REQ-031 binIn=123456, start pulse -> done exactly 21 cycles later; dig5..dig0=1,2,3,4,5,6; ovf=0.
REQ-032 binIn=0 then binIn=999999 back-to-back -> first done gives all 0; second gives all 9; ovf=0 for both.
REQ-033 binIn=1048575 -> ovf=1; digits 999999 with BCD_OVF_SATURATE_EN, 048575 without it.
REQ-034 start=1 with 123456, then start=1 with 777 five cycles later -> single done, digits 123456; busy high for cycles 1..21.
REQ-035 rst=1 at cycle 10 of a conversion -> next cycle busy=0 and digits 0; no done within 30 cycles.
REQ-036 start held high with constant binIn=42 -> done every 22 cycles; dig1=4, dig0=2, remaining digits 0.

Source files
------------

// File: rtl/copper_bcd_pkg.sv
// Shared widths, iteration bound and FSM encoding for the 20-bit to 6-digit BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package copper_bcd_pkg;

   localparam int BIN_W   = 20;            // binary input width
   localparam int NDIG    = 6;             // BCD digits presented at the outputs
   localparam int SCR_DIG = NDIG + 1;      // scratch digits; the extra one detects overflow
   localparam int SCR_W   = 4 * SCR_DIG;   // scratch width in bits
   localparam int CNT_W   = 5;             // iteration counter width

   // Last SHIFT iteration index: one shift per input bit.
   localparam logic [CNT_W-1:0] ITER_LAST = 5'd19;

   // Largest value representable in the six output digits.
   localparam int MAX_DEC = 999999;

   // FSM encoding kept as plain constants for compatibility with older tooling.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_LOAD  = 2'd2;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd6.sv
// Sequential double-dabble converter: 20-bit unsigned binary to six BCD digits plus overflow flag.
// Latency: done rises 21 cycles after start is accepted; one conversion per 22 cycles at best.
// Backpressure: start is only accepted in IDLE; a start seen while busy is dropped, never queued.
// Build option BCD_OVF_SATURATE_EN: when defined, an overflowing value loads 999999 instead of value mod 1000000.
module bin_to_bcd6
   import copper_bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] binIn,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       dig0,
   output logic [3:0]       dig1,
   output logic [3:0]       dig2,
   output logic [3:0]       dig3,
   output logic [3:0]       dig4,
   output logic [3:0]       dig5
);

   state_t              state;
   logic [BIN_W-1:0]    bin_sr;     // remaining binary bits, consumed MSB first
   logic [SCR_W-1:0]    scratch;    // seven-digit BCD accumulator
   logic [SCR_W-1:0]    adj;        // scratch after per-digit add-3 correction
   logic [CNT_W-1:0]    cnt;        // SHIFT iteration counter
   logic [4*NDIG-1:0]   dig_r;      // registered output digits, dig0 in the low nibble
   logic [4*NDIG-1:0]   load_dig;   // digits to be captured in LOAD
   logic                ovf_next;   // seventh digit nonzero: value above 999999

   // One correction cell per scratch digit, including the overflow digit.
   genvar g;
   generate
      for (g = 0; g < SCR_DIG; g++) begin : g_add3
         bcd_add3 u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
         );
      end
   endgenerate

   assign busy     = (state != ST_IDLE);
   assign ovf_next = (scratch[SCR_W-1 -: 4] != 4'd0);

   assign dig0 = dig_r[3:0];
   assign dig1 = dig_r[7:4];
   assign dig2 = dig_r[11:8];
   assign dig3 = dig_r[15:12];
   assign dig4 = dig_r[19:16];
   assign dig5 = dig_r[23:20];

   // Select the digits presented at LOAD: saturated or wrapped on overflow.
   always_comb begin
      load_dig = scratch[4*NDIG-1:0];
`ifdef BCD_OVF_SATURATE_EN
      if (ovf_next) begin
         load_dig = 24'h999999;
      end
`endif
   end

   // FSM, shift datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         bin_sr  <= '0;
         scratch <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         dig_r   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  bin_sr  <= binIn;
                  scratch <= '0;
                  cnt     <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Correct first, then shift the next binary bit into the BCD LSB.
               scratch <= {adj[SCR_W-2:0], bin_sr[BIN_W-1]};
               bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
               cnt     <= cnt + 5'd1;
               if (cnt == ITER_LAST) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               dig_r <= load_dig;
               ovf   <= ovf_next;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd6.sv
// Scoreboard bench for bin_to_bcd6: stimulus queues expected results, a monitor checks each done pulse.
// Latency: expects done exactly 21 cycles after the accepting edge.
// Backpressure: exercises ignored starts while busy and start held high.
module tb_bin_to_bcd6;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [19:0] binIn;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [3:0]  dig0, dig1, dig2, dig3, dig4, dig5;

   bin_to_bcd6 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .binIn (binIn),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf),
      .dig0  (dig0),
      .dig1  (dig1),
      .dig2  (dig2),
      .dig3  (dig3),
      .dig4  (dig4),
      .dig5  (dig5)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [23:0] digs;
      logic        ovf;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   wire [23:0] digs_now = {dig5, dig4, dig3, dig2, dig1, dig0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
      end
   endtask

   // Called at a negedge: the next rising edge accepts the request.
   task automatic issue(input logic [19:0] v, input logic [23:0] d, input logic o);
      exp_t e;
      start  = 1'b1;
      binIn  = v;
      e.due  = cyc + 22;
      e.digs = d;
      e.ovf  = o;
      sbq.push_back(e);
   endtask

   task automatic push_exp(input int due, input logic [23:0] d, input logic o);
      exp_t e;
      e.due  = due;
      e.digs = d;
      e.ovf  = o;
      sbq.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d pending required=0 pending", sbq.size());
         sbq.delete();
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk("done_cycle", cyc, mon_e.due);
            chk("digits", {8'h0, digs_now}, {8'h0, mon_e.digs});
            chk("ovf", {31'h0, ovf}, {31'h0, mon_e.ovf});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [23:0] big_digs;
`ifdef BCD_OVF_SATURATE_EN
      big_digs = 24'h999999;
`else
      big_digs = 24'h048575;
`endif
      rst   = 1'b1;
      start = 1'b0;
      binIn = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_ovf", {31'h0, ovf}, 32'h0);
      chk("rst_digits", {8'h0, digs_now}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Single conversion, then digits must hold.
      issue(20'd123456, 24'h123456, 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_drain(40);
      repeat (5) @(negedge clk);
      chk("hold_digits", {8'h0, digs_now}, 32'h123456);

      // 0 then 999999 back-to-back; binIn changes mid-conversion are ignored.
      start = 1'b1;
      binIn = 20'd0;
      k = cyc + 1;
      push_exp(k + 21, 24'h000000, 1'b0);
      push_exp(k + 43, 24'h999999, 1'b0);
      @(negedge clk);
      binIn = 20'd999999;
      while (cyc < k + 22) @(negedge clk);
      start = 1'b0;
      wait_drain(60);

      // Start while busy is dropped; busy spans 21 cycles.
      issue(20'd123456, 24'h123456, 1'b0);
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 22; i++) begin
         chk("busy_window", {31'h0, busy}, (i <= 21) ? 32'h1 : 32'h0);
         if (i == 5) begin
            start = 1'b1;
            binIn = 20'd777;
         end
         if (i == 6) start = 1'b0;
         @(negedge clk);
      end
      wait_drain(10);
      repeat (25) @(negedge clk);

      // Overflow: 1048575.
      issue(20'd1048575, big_digs, 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_drain(40);

      // Reset at cycle 10 of a conversion aborts it.
      start = 1'b1;
      binIn = 20'd654321;
      k = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < k + 9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_digits", {8'h0, digs_now}, 32'h0);
      chk("abort_ovf", {31'h0, ovf}, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      rst = 1'b0;
      repeat (30) @(negedge clk);

      // Start held high: a new result every 22 cycles.
      start = 1'b1;
      binIn = 20'd42;
      k = cyc + 1;
      push_exp(k + 21, 24'h000042, 1'b0);
      push_exp(k + 43, 24'h000042, 1'b0);
      push_exp(k + 65, 24'h000042, 1'b0);
      while (cyc < k + 44) @(negedge clk);
      start = 1'b0;
      wait_drain(80);
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
